// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA at BASE_ADDR feeds a byte FIFO, STATUS at BASE_ADDR+4.
// Define MMIO_UART_PARITY_EN to append an even-parity bit (11-bit frame).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx
);
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef MMIO_UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state, w_next;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic [7:0]      r_shift;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bitcnt;

    logic w_hit_tx, w_hit_st, w_full, w_empty, w_busy, w_pop, w_push, w_tick;
    logic w_unused;

    assign w_unused = &{1'b0, WriteData[31:8]};
    assign w_hit_tx = MemWrite && (ALUResult == BASE_ADDR);
    assign w_hit_st = MemWrite && (ALUResult == STAT_ADDR);
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_busy   = (r_state != S_IDLE);
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    // A pop in the same cycle frees the slot, so a full-FIFO push still lands.
    assign w_push   = w_hit_tx && (!w_full || w_pop);
    assign w_tick   = (r_baud == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        ReadData = 32'b0;
        if (ALUResult == STAT_ADDR)
            ReadData = {16'b0, 8'(r_count), 4'b0, r_ovf, w_busy, w_empty, w_full};
    end

    // FIFO storage needs no reset; pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= WriteData[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_shift <= 8'h00;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                r_shift <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_hit_tx && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (w_hit_st && WriteData[3])
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud   <= '0;
            r_bitcnt <= 3'd0;
        end else begin
            if (r_state == S_IDLE || w_tick) r_baud <= '0;
            else                              r_baud <= r_baud + 1'b1;
            if (r_state != S_DATA)            r_bitcnt <= 3'd0;
            else if (w_tick)                  r_bitcnt <= r_bitcnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_pop)  w_next = S_START;
            S_START:  if (w_tick) w_next = S_DATA;
`ifdef MMIO_UART_PARITY_EN
            S_DATA:   if (w_tick && r_bitcnt == 3'd7) w_next = S_PARITY;
            S_PARITY: if (w_tick) w_next = S_STOP;
`else
            S_DATA:   if (w_tick && r_bitcnt == 3'd7) w_next = S_STOP;
`endif
            S_STOP:   if (w_tick) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[r_bitcnt];
`ifdef MMIO_UART_PARITY_EN
            S_PARITY: tx = ^r_shift;
`endif
            default:  tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized scoreboard bench for mmio_uart_tx: a countdown/queue model predicts frames and STATUS,
// a line monitor decodes tx and pops the expected bytes. Honors MMIO_UART_PARITY_EN.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] STAT = BASE + 32'd4;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = STAT;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        tx;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .tx(tx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO as a queue, transmitter as a countdown of remaining frame cycles.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    int         m_busy = 0;
    bit         m_ovf = 0;
    bit         m_pop;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_q.delete(); exp_q.delete(); m_busy = 0; m_ovf = 0;
        end else begin
            m_pop = (m_busy == 0) && (m_q.size() > 0);
            if (m_busy > 0) m_busy--;
            if (m_pop) begin
                exp_q.push_back(m_q.pop_front());
                m_busy = FRAME;
            end
            if (MemWrite && ALUResult == BASE) begin
                if (m_q.size() < DEPTH) m_q.push_back(WriteData[7:0]);
                else m_ovf = 1;
            end
            if (MemWrite && ALUResult == STAT && WriteData[3]) m_ovf = 0;
        end
    end

    function automatic logic [31:0] model_stat();
        return {16'b0, 8'(m_q.size()), 4'b0, m_ovf, m_busy != 0,
                m_q.size() == 0, m_q.size() == DEPTH};
    endfunction

    // Line monitor: sample each bit mid-cell, abandon the frame on reset.
    initial begin
        logic [NB-1:0] bits;
        logic [7:0]    got;
        bit            abort;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                bits = '0;
                bits[0] = 1'b0;
                abort = 0;
                for (int c = 1; c <= (NB - 1) * CPB + CPB / 2; c++) begin
                    @(negedge clk);
                    if (reset) begin abort = 1; break; end
                    if (c % CPB == CPB / 2) bits[c / CPB] = tx;
                end
                if (!abort) begin
                    got = bits[8:1];
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL frame_unexpected: got %02h expected no frame", got);
                    end else begin
                        chk("frame_byte", 32'(got), 32'(exp_q.pop_front()));
`ifdef MMIO_UART_PARITY_EN
                        chk("parity_bit", 32'(bits[9]), 32'(^got));
`endif
                        chk("stop_bit", 32'(bits[NB-1]), 32'd1);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; ALUResult = a; WriteData = d;
        step();
        MemWrite = 1'b0; ALUResult = STAT;
    endtask

    task automatic chk_stat(input string name);
        ALUResult = STAT;
        #1;
        chk(name, ReadData, model_stat());
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((m_q.size() != 0 || m_busy != 0 || exp_q.size() != 0) && k < 3000) begin
            step(); k++;
        end
        chk(name, 32'(exp_q.size() + m_q.size()), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit low_seen;
        logic [7:0] b;
        step(); step();
        reset = 1'b0;
        step();
        // Reset state
        ALUResult = STAT; #1;
        chk("reset_status", ReadData, 32'h0000_0002);
        chk("reset_tx", 32'(tx), 32'd1);
        ALUResult = BASE; #1;
        chk("read_other_zero", ReadData, 32'h0);

        // Single frame: start bit one edge after the write edge, busy for exactly FRAME cycles
        wr(BASE, 32'h0000_00A5);
        chk("tx_idle_at_push", 32'(tx), 32'd1);
        step();
        chk("start_latency", 32'(tx), 32'd0);
        for (int i = 0; i < FRAME - 1; i++) step();
        ALUResult = STAT; #1;
        chk("busy_last_cycle", 32'(ReadData[2]), 32'd1);
        step();
        ALUResult = STAT; #1;
        chk("busy_done", 32'(ReadData[2]), 32'd0);
        chk_stat("status_after_frame");
        wait_drain("drain_a5");

`ifdef MMIO_UART_PARITY_EN
        wr(BASE, 32'h0000_0007);
        for (int i = 0; i < FRAME; i++) step();
        ALUResult = STAT; #1;
        chk("par_busy_last", 32'(ReadData[2]), 32'd1);
        step();
        ALUResult = STAT; #1;
        chk("par_busy_done", 32'(ReadData[2]), 32'd0);
        wait_drain("drain_07");
`endif

        // Six back-to-back writes: one popped, four held, sixth dropped
        MemWrite = 1'b1; ALUResult = BASE;
        for (int i = 0; i < 6; i++) begin
            WriteData = {24'h0, 8'(8'h11 * (i + 1))};
            step();
        end
        MemWrite = 1'b0;
        ALUResult = STAT; #1;
        chk("overflow_status", ReadData, 32'h0000_040D);
        chk_stat("overflow_model");
        wr(STAT, 32'h0000_0008);
        ALUResult = STAT; #1;
        chk("ovf_clear", ReadData, 32'h0000_0405);

        // Write landing on the pop edge with the FIFO full
        k = 0;
        while (m_busy != 0 && k < 200) begin step(); k++; end
        chk("reach_pop_cycle", 32'(m_busy), 32'd0);
        wr(BASE, 32'h0000_003C);
        ALUResult = STAT; #1;
        chk("push_pop_full", ReadData, 32'h0000_0405);
        chk_stat("push_pop_model");
        wait_drain("drain_burst");

        // Reset mid-frame
        wr(BASE, {24'h0, 8'($urandom)});
        wr(BASE, {24'h0, 8'($urandom)});
        k = 0;
        while (tx !== 1'b0 && k < 50) begin step(); k++; end
        chk("frame_started", 32'(tx), 32'd0);
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        #1;
        chk("reset_tx_immediate", 32'(tx), 32'd1);
        step(); step();
        reset = 1'b0;
        step();
        ALUResult = STAT; #1;
        chk("status_after_abort", ReadData, 32'h0000_0002);
        low_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1) low_seen = 1;
        end
        chk("no_frames_after_reset", 32'(low_seen), 32'd0);

        // Randomized traffic
        for (int op = 0; op < 300; op++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    b = 8'($urandom);
                    wr(BASE, {24'h0, b});
                end
                5: wr(STAT, $urandom);
                6: wr($urandom & 32'h0000_FFFC, $urandom);
                default: begin
                    k = $urandom_range(1, 30);
                    for (int i = 0; i < k; i++) step();
                end
            endcase
            if ($urandom_range(0, 3) == 0) chk_stat("rand_status");
        end
        wait_drain("drain_random");
        chk_stat("final_status");
        chk("final_tx", 32'(tx), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL take parameter BASE_ADDR, default 32'hFFFF_0000, the byte address of the TXDATA register; STATUS is at BASE_ADDR+4.
REQ-002 The block SHALL take parameter CLKS_PER_BIT, default 16, the clk cycles per serial bit (minimum 2).
REQ-003 The block SHALL take parameter FIFO_DEPTH, default 8, the transmit FIFO depth (power of 2, minimum 2).
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 MemWrite  input  1  store strobe from the core data port.
REQ-007 ALUResult  input  32  data-port byte address from the core.
REQ-008 WriteData  input  32  store data from the core.
REQ-009 ReadData  output  32  combinational read data for the presented address.
REQ-010 tx  output  1  serial line; idle high.

Function
REQ-011 A write hit SHALL be MemWrite=1 with ALUResult==BASE_ADDR; it pushes WriteData[7:0] into the FIFO at the clk edge.
REQ-012 A write hit with the FIFO full and no pop in the same cycle SHALL drop the byte and set sticky STATUS bit3 (overflow).
REQ-013 A push and a pop in the same cycle SHALL both take effect: count is unchanged and the full-FIFO push is not dropped.
REQ-014 MemWrite=1 with ALUResult==BASE_ADDR+4 and WriteData[3]=1 SHALL clear overflow; other WriteData bits are ignored.
REQ-015 ReadData SHALL be {16'b0, count[7:0], 4'b0, overflow, busy, empty, full} when ALUResult==BASE_ADDR+4, and 32'b0 for any other address.
REQ-016 count SHALL be the FIFO occupancy 0..FIFO_DEPTH; full = (count==FIFO_DEPTH); empty = (count==0); busy = (state!=IDLE).
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE: tx=1; if FIFO non-empty, pop the head into the shift register and go to START at the next edge.
REQ-018 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit counter selects the bit; after bit 7 it SHALL go to STOP.
REQ-020 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-021 The baud counter SHALL count 0..CLKS_PER_BIT-1, reload to 0 on each bit boundary, and wrap with no drift.
REQ-022 Latency: a write hit into an empty FIFO with the FSM idle at edge N SHALL give tx=0 after edge N+1.
REQ-023 Back-to-back bytes SHALL leave exactly one IDLE cycle between STOP and the next START.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Writes to any other address SHALL have no effect.

Reset
REQ-026 While reset=1, the block SHALL force state=IDLE, tx=1, count=0, both pointers=0, overflow=0, and all counters=0, independent of clk.
REQ-027 Reset asserted mid-frame SHALL abort the frame; tx goes high immediately and FIFO contents are discarded.
REQ-028 After reset deasserts, ReadData at BASE_ADDR+4 SHALL read 32'h0000_0002.

Configuration
REQ-029 With macro MMIO_UART_PARITY_EN defined, a PARITY state SHALL be inserted between DATA and STOP.
- PARITY sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 11-bit frame.
REQ-030 Without MMIO_UART_PARITY_EN, the frame SHALL be 10 bits (start, 8 data, stop), with no PARITY state and no parity logic.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4, parity off unless stated)
REQ-031 Reset, then read BASE_ADDR+4 -> ReadData=32'h0000_0002 and tx=1.
REQ-032 Write 8'hA5 to BASE_ADDR -> tx=0 one edge later, then data bits 1,0,1,0,0,1,0,1 each 4 cycles, then stop=1; total 40 cycles; busy=0 afterwards.
REQ-033 Write 6 bytes back-to-back while idle -> first is popped immediately, 4 held (full=1), 6th dropped, overflow=1; 5 frames sent in order.
REQ-034 Write BASE_ADDR+4 with WriteData=32'h8 -> overflow=0; with FIFO full and the FSM popping, a write in the same cycle is accepted and count stays 4.
REQ-035 Assert reset at cycle 10 of a frame -> tx=1 immediately, STATUS=32'h0000_0002 after release, no further frames.
REQ-036 With MMIO_UART_PARITY_EN defined, write 8'h07 -> parity bit=1 follows bit 7, frame is 44 cycles.
